// File: rtl/paint_pkg.sv
// Shared constants and types for the paint framebuffer arbiter.
// Color codes, framebuffer geometry and the arbiter state type.
package paint_pkg;

  localparam int unsigned FB_DEPTH = 19200;
  localparam int unsigned ADDR_W   = 15;

  localparam logic [2:0] CODE_BLACK   = 3'd0;
  localparam logic [2:0] CODE_RED     = 3'd1;
  localparam logic [2:0] CODE_GREEN   = 3'd2;
  localparam logic [2:0] CODE_BLUE    = 3'd3;
  localparam logic [2:0] CODE_YELLOW  = 3'd4;
  localparam logic [2:0] CODE_CYAN    = 3'd5;
  localparam logic [2:0] CODE_MAGENTA = 3'd6;
  localparam logic [2:0] CODE_WHITE   = 3'd7;

  // A cleared canvas reads back as white paper.
  localparam logic [2:0] CODE_ERASE   = CODE_WHITE;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_t;

endpackage

// File: rtl/paint_fifo.sv
// Synchronous FIFO for queued paint writes, with a single-cycle flush.
// Depth must be a power of two so the pointers wrap naturally.
module paint_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out read > clear write > queued paint write.
// Define FB_CLEAR_EN to build the full-screen clear sequencer; otherwise clear_start is ignored.
module fb_arbiter #(
  parameter int unsigned FB_DEPTH   = paint_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W     = paint_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [2:0]        vga_rd_code,
  output logic              vga_rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_code,
  output logic              wr_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_wdata,
  input  logic [2:0]        fb_rdata
);

  import paint_pkg::*;

  localparam int unsigned         EntryW   = ADDR_W + 3;
  localparam logic [ADDR_W-1:0]   LastAddr = ADDR_W'(FB_DEPTH - 1);

  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [EntryW-1:0] fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [2:0]        head_code;
  logic              clear_go;
  logic [ADDR_W-1:0] clear_addr;
  logic              rd_valid_q;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
`ifdef FB_CLEAR_EN
  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // A cycle stolen by scan-out holds the counter.
        if (!vga_rd_req) begin
          if (cnt_q == LastAddr) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_go   = (state_q == IDLE) && clear_start;
  assign clear_addr = cnt_q;
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign clear_busy         = 1'b0;
  assign clear_go           = 1'b0;
  assign clear_addr         = '0;
`endif

  // ---------------------------------------------------------------------------
  // Paint write queue
  // ---------------------------------------------------------------------------
  // A write offered alongside an accepted clear_start is refused, not queued.
  assign wr_ready  = !fifo_full && !clear_busy && !clear_go;
  assign fifo_push = wr_valid && wr_ready;

  paint_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_paint_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (clear_go),
    .push_i  (fifo_push),
    .wdata_i ({wr_addr, wr_code}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_addr = fifo_head[EntryW-1:3];
  assign head_code = fifo_head[2:0];

  // ---------------------------------------------------------------------------
  // RAM port arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    fb_en    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    fifo_pop = 1'b0;
    if (!reset) begin
      if (vga_rd_req) begin
        fb_en   = 1'b1;
        fb_addr = vga_rd_addr;
      end else if (clear_busy) begin
        fb_en    = 1'b1;
        fb_we    = 1'b1;
        fb_addr  = clear_addr;
        fb_wdata = CODE_ERASE;
      end else if (!fifo_empty && !clear_go) begin
        // Out-of-range entries still consume their slot but never reach the RAM.
        fifo_pop = 1'b1;
        if (head_addr <= LastAddr) begin
          fb_en    = 1'b1;
          fb_we    = 1'b1;
          fb_addr  = head_addr;
          fb_wdata = head_code;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= vga_rd_req;
    end
  end

  assign vga_rd_valid = rd_valid_q;
  assign vga_rd_code  = fb_rdata;

endmodule
